// File: rtl/ita_gelu_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ita_gelu_cfg                                                   |
// | Desc    : Double-buffered i-GELU constant / requant parameter registers. |
// |           Optional readback port when ITA_GELU_CFG_READBACK_EN defined.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ita_gelu_cfg #(
    parameter int GELU_CONSTANTS_WIDTH = 16,
    parameter int EMS                  = 8,
    parameter int SHIFT_W              = 5,
    parameter int WI                   = 8,
    parameter int DATA_W               = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [2:0]                      cfg_addr_i,
    input  logic [DATA_W-1:0]               cfg_data_i,
    input  logic                            busy_i,
    output logic [GELU_CONSTANTS_WIDTH-1:0] one_o,
    output logic [GELU_CONSTANTS_WIDTH-1:0] b_o,
    output logic [GELU_CONSTANTS_WIDTH-1:0] c_o,
    output logic [EMS-1:0]                  eps_mult_o,
    output logic [SHIFT_W-1:0]              right_shift_o,
    output logic [WI-1:0]                   add_o,
    output logic                            params_valid_o,
    output logic                            apply_o,
    output logic                            err_o
`ifdef ITA_GELU_CFG_READBACK_EN
    ,
    input  logic [2:0]                      rd_addr_i,
    output logic [DATA_W-1:0]               rd_data_o
`endif
);

    localparam int         c_CW         = GELU_CONSTANTS_WIDTH;
    localparam logic [2:0] c_ADDR_ONE   = 3'd0;
    localparam logic [2:0] c_ADDR_B     = 3'd1;
    localparam logic [2:0] c_ADDR_C     = 3'd2;
    localparam logic [2:0] c_ADDR_EPS   = 3'd3;
    localparam logic [2:0] c_ADDR_SHIFT = 3'd4;
    localparam logic [2:0] c_ADDR_ADD   = 3'd5;
    localparam logic [2:0] c_ADDR_COMMIT = 3'd6;
    localparam logic [2:0] c_ADDR_RSVD  = 3'd7;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_APPLY   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_hs;
    logic               w_unused_data;

    logic [c_CW-1:0]    r_sh_one, r_sh_b, r_sh_c;
    logic [EMS-1:0]     r_sh_eps;
    logic [SHIFT_W-1:0] r_sh_shift;
    logic [WI-1:0]      r_sh_add;

    logic [c_CW-1:0]    r_one, r_b, r_c;
    logic [EMS-1:0]     r_eps;
    logic [SHIFT_W-1:0] r_shift;
    logic [WI-1:0]      r_add;
    logic               r_params_valid;
    logic               r_apply;
    logic               r_err;

    assign cfg_ready_o   = rst_ni & (r_state == S_IDLE);
    assign w_hs          = cfg_valid_i & cfg_ready_o;
    assign w_unused_data = ^cfg_data_i[DATA_W-1:c_CW];

    // Commit is only legal with a negative b, since the clip bound is -b.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs && (cfg_addr_i == c_ADDR_COMMIT) && r_sh_b[c_CW-1])
                    w_state_next = S_PENDING;
            end
            S_PENDING: begin
                if (!busy_i)
                    w_state_next = S_APPLY;
            end
            S_APPLY:  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state        <= S_IDLE;
            r_sh_one       <= '0;
            r_sh_b         <= '0;
            r_sh_c         <= '0;
            r_sh_eps       <= '0;
            r_sh_shift     <= '0;
            r_sh_add       <= '0;
            r_one          <= '0;
            r_b            <= '0;
            r_c            <= '0;
            r_eps          <= '0;
            r_shift        <= '0;
            r_add          <= '0;
            r_params_valid <= 1'b0;
            r_apply        <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_apply <= (r_state == S_APPLY);
            if (w_hs) begin
                case (cfg_addr_i)
                    c_ADDR_ONE:    r_sh_one   <= cfg_data_i[c_CW-1:0];
                    c_ADDR_B:      r_sh_b     <= cfg_data_i[c_CW-1:0];
                    c_ADDR_C:      r_sh_c     <= cfg_data_i[c_CW-1:0];
                    c_ADDR_EPS:    r_sh_eps   <= cfg_data_i[EMS-1:0];
                    c_ADDR_SHIFT:  r_sh_shift <= cfg_data_i[SHIFT_W-1:0];
                    c_ADDR_ADD:    r_sh_add   <= cfg_data_i[WI-1:0];
                    c_ADDR_COMMIT: if (!r_sh_b[c_CW-1]) r_err <= 1'b1;
                    c_ADDR_RSVD:   r_err <= 1'b1;
                    default:       r_err <= r_err;
                endcase
            end
            if (r_state == S_APPLY) begin
                r_one          <= r_sh_one;
                r_b            <= r_sh_b;
                r_c            <= r_sh_c;
                r_eps          <= r_sh_eps;
                r_shift        <= r_sh_shift;
                r_add          <= r_sh_add;
                r_params_valid <= 1'b1;
            end
        end
    end

    assign one_o          = r_one;
    assign b_o            = r_b;
    assign c_o            = r_c;
    assign eps_mult_o     = r_eps;
    assign right_shift_o  = r_shift;
    assign add_o          = r_add;
    assign params_valid_o = r_params_valid;
    assign apply_o        = r_apply;
    assign err_o          = r_err;

`ifdef ITA_GELU_CFG_READBACK_EN
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_data <= '0;
        end else begin
            case (rd_addr_i)
                c_ADDR_ONE:    r_rd_data <= {{(DATA_W-c_CW){r_one[c_CW-1]}}, r_one};
                c_ADDR_B:      r_rd_data <= {{(DATA_W-c_CW){r_b[c_CW-1]}}, r_b};
                c_ADDR_C:      r_rd_data <= {{(DATA_W-c_CW){r_c[c_CW-1]}}, r_c};
                c_ADDR_EPS:    r_rd_data <= {{(DATA_W-EMS){1'b0}}, r_eps};
                c_ADDR_SHIFT:  r_rd_data <= {{(DATA_W-SHIFT_W){1'b0}}, r_shift};
                c_ADDR_ADD:    r_rd_data <= {{(DATA_W-WI){r_add[WI-1]}}, r_add};
                c_ADDR_COMMIT: r_rd_data <= {{(DATA_W-4){1'b0}}, r_err, r_params_valid, r_state};
                default:       r_rd_data <= '0;
            endcase
        end
    end

    assign rd_data_o = r_rd_data;
`else
    // Readback port absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ita_gelu_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ita_gelu_cfg                                                |
// | Desc    : Self-checking bench for ita_gelu_cfg (table + scoreboard).     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_ita_gelu_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        busy = 1'b0;
    logic [15:0] one, b, c;
    logic [7:0]  eps;
    logic [4:0]  shift;
    logic [7:0]  add;
    logic        pv, apply, err;
`ifdef ITA_GELU_CFG_READBACK_EN
    logic [2:0]  rd_addr = 3'd0;
    logic [31:0] rd_data;
`endif

    ita_gelu_cfg dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .busy_i(busy),
        .one_o(one), .b_o(b), .c_o(c), .eps_mult_o(eps), .right_shift_o(shift),
        .add_o(add), .params_valid_o(pv), .apply_o(apply), .err_o(err)
`ifdef ITA_GELU_CFG_READBACK_EN
        , .rd_addr_i(rd_addr), .rd_data_o(rd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_active;
    } vec_t;

    typedef struct {
        logic [15:0] one, b, c;
        logic [7:0]  eps;
        logic [4:0]  shift;
        logic [7:0]  add;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_apply = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every apply pulse must match the oldest expected set.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && apply === 1'b1) begin
            n_apply++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_apply: apply_o=1 with no pending commit (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("apply_cycle", cyc, mon_e.cyc);
                chk("apply_one", {16'd0, one}, {16'd0, mon_e.one});
                chk("apply_b", {16'd0, b}, {16'd0, mon_e.b});
                chk("apply_c", {16'd0, c}, {16'd0, mon_e.c});
                chk("apply_eps", {24'd0, eps}, {24'd0, mon_e.eps});
                chk("apply_shift", {27'd0, shift}, {27'd0, mon_e.shift});
                chk("apply_add", {24'd0, add}, {24'd0, mon_e.add});
                chk("apply_pv", {31'd0, pv}, 32'd1);
            end
        end
    end

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, output int hs);
        int n;
        n = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL write_timeout: ready stayed %0b for %0d cycles, required 1", cfg_ready, n);
        end
        @(posedge clk);
        #1;
        hs = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_one"}, {16'd0, one}, 32'd0);
        chk({tag, "_b"}, {16'd0, b}, 32'd0);
        chk({tag, "_c"}, {16'd0, c}, 32'd0);
        chk({tag, "_eps"}, {24'd0, eps}, 32'd0);
        chk({tag, "_shift"}, {27'd0, shift}, 32'd0);
        chk({tag, "_add"}, {24'd0, add}, 32'd0);
        chk({tag, "_pv"}, {31'd0, pv}, 32'd0);
        chk({tag, "_apply"}, {31'd0, apply}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    function automatic logic [31:0] active_by_addr(input logic [2:0] a);
        case (a)
            3'd0:    return {16'd0, one};
            3'd1:    return {16'd0, b};
            3'd2:    return {16'd0, c};
            3'd3:    return {24'd0, eps};
            3'd4:    return {27'd0, shift};
            3'd5:    return {24'd0, add};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        exp_t e;
        int   hs;
        int   n;

        // Upper data bits are junk on purpose; C is written twice (last wins).
        vecs[0] = '{3'd0, 32'hABCD_0100, 32'h0000_0100};
        vecs[1] = '{3'd1, 32'h0000_FF00, 32'h0000_FF00};
        vecs[2] = '{3'd2, 32'h0000_1234, 32'h0000_0040};
        vecs[3] = '{3'd2, 32'hFFFF_0040, 32'h0000_0040};
        vecs[4] = '{3'd3, 32'h0000_0003, 32'h0000_0003};
        vecs[5] = '{3'd4, 32'hFFFF_FFE4, 32'h0000_0004};
        vecs[6] = '{3'd5, 32'hFFFF_FFFE, 32'h0000_00FE};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, cfg_ready}, 32'd1);

        // Basic program + commit, busy low
        foreach (vecs[i]) do_write(vecs[i].addr, vecs[i].data, hs);
        e = '{16'h0100, 16'hFF00, 16'h0040, 8'd3, 5'd4, 8'hFE, 0};
        do_write(3'd6, 32'd0, hs);
        e.cyc = hs + 2;
        sb.push_back(e);
        @(negedge clk);
        chk("pending_ready", {31'd0, cfg_ready}, 32'd0);
        chk("pending_b_old", {16'd0, b}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t1_n_apply", n_apply, 1);
        chk("t1_pv", {31'd0, pv}, 32'd1);
        chk("t1_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 7; i++)
            chk("t1_table", active_by_addr(vecs[i].addr), vecs[i].exp_active);

`ifdef ITA_GELU_CFG_READBACK_EN
        rd_addr = 3'd1; @(posedge clk); #1;
        chk("rd_b", rd_data, 32'hFFFF_FF00);
        rd_addr = 3'd6; @(posedge clk); #1;
        chk("rd_status", rd_data, 32'h0000_0004);
        rd_addr = 3'd4; @(posedge clk); #1;
        chk("rd_shift", rd_data, 32'h0000_0004);
        rd_addr = 3'd5; @(posedge clk); #1;
        chk("rd_add", rd_data, 32'hFFFF_FFFE);
        rd_addr = 3'd7; @(posedge clk); #1;
        chk("rd_rsvd", rd_data, 32'd0);
`endif

        // Commit held off by busy, with a B write stalled during PENDING
        do_write(3'd0, 32'h0000_0180, hs);
        do_write(3'd5, 32'h0000_0005, hs);
        busy = 1'b1;
        do_write(3'd6, 32'd0, hs);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_data = 32'h0000_7FFF;
            end
            chk("busy_ready", {31'd0, cfg_ready}, 32'd0);
            chk("busy_one", {16'd0, one}, 32'h0000_0100);
        end
        busy = 1'b0;
        e = '{16'h0180, 16'hFF00, 16'h0040, 8'd3, 5'd4, 8'h05, cyc + 2};
        sb.push_back(e);
        n = 0;
        while (!cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_wait", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("t2_b_after", {16'd0, b}, 32'h0000_FF00);
        chk("t2_n_apply", n_apply, 2);

        // Rejected commit: b >= 0
        do_write(3'd1, 32'h0000_0010, hs);
        do_write(3'd6, 32'd0, hs);
        repeat (3) @(negedge clk);
        chk("rej_err", {31'd0, err}, 32'd1);
        chk("rej_b", {16'd0, b}, 32'h0000_FF00);
        chk("rej_one", {16'd0, one}, 32'h0000_0180);
        chk("rej_pv", {31'd0, pv}, 32'd1);
        chk("rej_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rej_n_apply", n_apply, 2);

        // Reset while PENDING discards the commit
        do_write(3'd1, 32'h0000_FF00, hs);
        busy = 1'b1;
        do_write(3'd6, 32'd0, hs);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, cfg_ready}, 32'd0);
        chk_all_zero("midrst");
`ifdef ITA_GELU_CFG_READBACK_EN
        chk("midrst_rd", rd_data, 32'd0);
`endif
        rst_n = 1'b1;
        busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_n_apply", n_apply, 2);
        chk("midrst_idle", {31'd0, cfg_ready}, 32'd1);
        chk("midrst_b", {16'd0, b}, 32'd0);

        // Commit on an all-zero shadow (b == 0 boundary)
        do_write(3'd6, 32'd0, hs);
        repeat (2) @(negedge clk);
        chk("zero_err", {31'd0, err}, 32'd1);
        chk("zero_pv", {31'd0, pv}, 32'd0);
        chk("zero_n_apply", n_apply, 2);

        // Reserved address from a fresh reset
        do_reset();
        chk("rsvd_pre_err", {31'd0, err}, 32'd0);
        do_write(3'd7, 32'h0000_1234, hs);
        @(negedge clk);
        chk("rsvd_err", {31'd0, err}, 32'd1);
        chk("rsvd_b", {16'd0, b}, 32'd0);
        chk("rsvd_one", {16'd0, one}, 32'd0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
